nv_fifo_ctrl_rwsp_128x129: RTL and testbench

//  Valid/ready FIFO controller wrapped around the nv_ram_rwsp_128x129 storage macro.
//  It sits directly upstream and downstream of that RAM:
//  - drives its write port (wa/we/di) and read port (ra/re/ore);
//  - absorbs the 2-cycle registered read latency of the macro in a small output skid buffer.

---
 rtl/nv_fifo_ctrl_rwsp_128x129.sv | 92 +++++++++
 tb/tb_nv_fifo_ctrl_rwsp_128x129.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/nv_fifo_ctrl_rwsp_128x129.sv
// Valid/ready FIFO controller around the nv_ram_rwsp_128x129 macro. Reads are
// credit-limited so the 2-cycle registered RAM latency always lands in the skid buffer.
module nv_fifo_ctrl_rwsp_128x129 #(
  parameter int DEPTH      = 128,
  parameter int AW         = 7,
  parameter int DW         = 129,
  parameter int SKID_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  output logic [7:0]    fifo_count,
  output logic [AW-1:0] ram_wa,
  output logic          ram_we,
  output logic [DW-1:0] ram_di,
  output logic [AW-1:0] ram_ra,
  output logic          ram_re,
  output logic          ram_ore,
  input  logic [DW-1:0] ram_dout,
  input  logic [31:0]   pwrbus_ram_pd
);
  localparam int SW = $clog2(SKID_DEPTH);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   ram_cnt;
  logic [3:1]    vld_pipe;
  logic [SW-1:0] skid_wp, skid_rp;
  logic [SW:0]   skid_cnt;
  logic [DW-1:0] skid_mem [SKID_DEPTH];
  logic          wr_acc, pop, issue, push;
  logic [1:0]    inflight;
  logic [SW+1:0] credit;
  logic          unused_pwr;

  // Power bus is consumed by the parent's RAM instance only.
  assign unused_pwr = ^pwrbus_ram_pd;

  assign wr_prdy  = !rst && (ram_cnt != (AW+1)'(DEPTH));
  assign wr_acc   = wr_pvld & wr_prdy;
  assign rd_pvld  = !rst && (skid_cnt != '0);
  assign pop      = rd_pvld & rd_prdy;
  assign push     = vld_pipe[2];
  assign inflight = 2'(vld_pipe[1]) + 2'(vld_pipe[2]) + 2'(vld_pipe[3]);
  // v3 is already in the skid, so counting it here is conservative but never overflows.
  assign credit   = (SW+2)'(skid_cnt) + (SW+2)'(inflight) - (SW+2)'(pop);
  assign issue    = !rst && (ram_cnt != '0) && (credit < (SW+2)'(SKID_DEPTH));

  assign ram_we  = wr_acc;
  assign ram_wa  = wr_ptr;
  assign ram_di  = wr_pd;
  assign ram_re  = issue;
  assign ram_ra  = rd_ptr;
  assign ram_ore = !rst && vld_pipe[1];
  assign rd_pd   = skid_mem[skid_rp];

  // Occupancy counts only reads whose data has not yet reached the skid (v1, v2).
  assign fifo_count = rst ? 8'd0
                          : 8'(ram_cnt) + 8'(skid_cnt) + 8'(vld_pipe[1]) + 8'(vld_pipe[2]);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ram_cnt  <= '0;
      vld_pipe <= '0;
      skid_wp  <= '0;
      skid_rp  <= '0;
      skid_cnt <= '0;
    end else begin
      wr_ptr   <= wr_ptr + AW'(wr_acc);
      rd_ptr   <= rd_ptr + AW'(issue);
      ram_cnt  <= ram_cnt + (AW+1)'(wr_acc) - (AW+1)'(issue);
      vld_pipe <= {vld_pipe[2:1], issue};
      skid_wp  <= skid_wp + SW'(push);
      skid_rp  <= skid_rp + SW'(pop);
      skid_cnt <= skid_cnt + (SW+1)'(push) - (SW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) skid_mem[skid_wp] <= ram_dout;
  end

  a_skid_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && skid_cnt == (SW+1)'(SKID_DEPTH)));

endmodule

// File: tb/tb_nv_fifo_ctrl_rwsp_128x129.sv
// Bench for nv_fifo_ctrl_rwsp_128x129: behavioural RAM macro plus a queue scoreboard
// that predicts contents, order and occupancy from accepted/popped handshakes.
module tb_nv_fifo_ctrl_rwsp_128x129;
  localparam int DEPTH = 128, AW = 7, DW = 129, SKID = 4;
  localparam logic [DW-1:0] PAT1 = 129'h1_DEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;

  logic          clk = 0, rst = 1;
  logic          wr_pvld = 0, wr_prdy, rd_pvld, rd_prdy = 0;
  logic [DW-1:0] wr_pd = '0, rd_pd, ram_di, ram_dout;
  logic [7:0]    fifo_count;
  logic [AW-1:0] ram_wa, ram_ra;
  logic          ram_we, ram_re, ram_ore;
  logic [31:0]   pwrbus_ram_pd = '0;

  nv_fifo_ctrl_rwsp_128x129 dut (
    .clk(clk), .rst(rst), .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
    .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd), .fifo_count(fifo_count),
    .ram_wa(ram_wa), .ram_we(ram_we), .ram_di(ram_di), .ram_ra(ram_ra),
    .ram_re(ram_re), .ram_ore(ram_ore), .ram_dout(ram_dout), .pwrbus_ram_pd(pwrbus_ram_pd)
  );

  always #5 clk = ~clk;

  // Storage macro: address captured on re, output register loaded on ore.
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] ra_q = '0;
  logic [DW-1:0] dout_q = '0;
  assign ram_dout = dout_q;
  always @(posedge clk) begin
    if (ram_we)  mem[ram_wa] <= ram_di;
    if (ram_re)  ra_q <= ram_ra;
    if (ram_ore) dout_q <= mem[ra_q];
  end

  int n_chk = 0, n_pass = 0;
  logic [DW-1:0] q[$];
  logic last_acc, last_pop, last_re, last_ore, last_pvld, last_prdy;
  logic [DW-1:0] last_pd;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] rnd_pd();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  // One clock: drive, check against scoreboard, then advance scoreboard on the edge.
  task automatic cyc(input logic r, input logic wv, input logic [DW-1:0] wd, input logic rr);
    @(negedge clk);
    rst = r; wr_pvld = wv; wr_pd = wd; rd_prdy = rr;
    #1;
    last_re = ram_re; last_ore = ram_ore; last_pvld = rd_pvld;
    last_prdy = wr_prdy; last_pd = rd_pd;
    if (r) begin
      chk("rst_outs", DW'({wr_prdy, rd_pvld, ram_we, ram_re, ram_ore, fifo_count}), '0);
    end else begin
      chk("count", DW'(fifo_count), DW'(q.size()));
      chk("count_max", DW'(fifo_count <= 8'd132), 1);
      if (rd_pvld) begin
        chk("pvld_has_data", DW'(q.size() != 0), 1);
        if (q.size() != 0) chk("data", rd_pd, q[0]);
      end
    end
    last_acc = !r && wv && wr_prdy;
    last_pop = !r && rd_pvld && rr;
    @(posedge clk);
    if (r) q.delete();
    else begin
      if (last_pop) void'(q.pop_front());
      if (last_acc) q.push_back(wd);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && q.size() != 0; i++) cyc(0, 0, '0, 1);
    chk("drain_empty", DW'(q.size()), 0);
  endtask

  initial begin
    int acc, res, k;
    // 1: reset and single-word latency
    cyc(1, 0, '0, 0);
    cyc(1, 1, PAT1, 1);
    cyc(0, 1, PAT1, 1);
    chk("t1_acc_c0", DW'(last_acc), 1);
    chk("t1_no_re_c0", DW'(last_re), 0);
    cyc(0, 0, '0, 1); chk("t1_re_c1", DW'(last_re), 1);
    cyc(0, 0, '0, 1); chk("t1_ore_c2", DW'(last_ore), 1);
    cyc(0, 0, '0, 1); chk("t1_pvld_c3", DW'(last_pvld), 0);
    cyc(0, 0, '0, 1); chk("t1_pvld_c4", DW'(last_pvld), 1); chk("t1_pd", last_pd, PAT1);

    // 2: fill to capacity under backpressure
    acc = 0; res = 0;
    for (int i = 0; i < 300; i++) begin
      cyc(0, 1, DW'(acc), 0);
      if (last_re) res++;
      if (last_acc) acc++;
      if (!last_prdy) break;
    end
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, '0, 0);
      if (last_re) res++;
      chk("t2_stall", DW'(last_prdy), 0);
    end
    chk("t2_accepts", DW'(acc), 132);
    chk("t2_fifo_count", DW'(fifo_count), 132);
    chk("t2_re_pulses", DW'(res), 4);
    k = 0;
    for (int i = 0; i < 400 && q.size() != 0; i++) begin
      cyc(0, 0, '0, 1);
      if (last_pop) begin chk("t2_order", last_pd, DW'(k)); k++; end
    end
    chk("t2_popped", DW'(k), 132);

    // 3: streaming at full rate across pointer wraps
    for (int i = 0; i < 300; i++) begin
      cyc(0, 1, DW'(1000 + i), 1);
      chk("t3_wr_prdy", DW'(last_prdy), 1);
      chk("t3_cnt_le5", DW'(fifo_count <= 8'd5), 1);
      if (i >= 4) chk("t3_tput", DW'(last_pop), 1);
    end
    drain();

    // 4: random traffic against the scoreboard
    for (int i = 0; i < 10000; i++)
      cyc(0, $urandom_range(0, 1) == 1, rnd_pd(), $urandom_range(0, 1) == 1);
    drain();

    // 5: simultaneous write/issue at ram_cnt=127, then full at 128
    cyc(1, 0, '0, 0);
    for (int i = 0; i < 131; i++) cyc(0, 1, DW'(5000 + i), 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, '0, 0);
    chk("t5_setup", DW'(fifo_count), 131);
    cyc(0, 1, DW'(6000), 1);
    chk("t5_acc", DW'(last_acc), 1);
    chk("t5_re", DW'(last_re), 1);
    cyc(0, 1, DW'(6001), 0);
    chk("t5_prdy_127", DW'(last_prdy), 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, DW'(7000), 0);
      chk("t5_full", DW'(last_prdy), 0);
      chk("t5_no_re", DW'(last_re), 0);
    end
    cyc(0, 0, '0, 1);
    chk("t5_issue", DW'(last_re), 1);
    cyc(0, 0, '0, 0);
    chk("t5_prdy_back", DW'(last_prdy), 1);
    drain();

    // 6: reset with reads in flight
    for (int i = 0; i < 10; i++) cyc(0, 1, DW'(9000 + i), 0);
    cyc(1, 0, '0, 1);
    cyc(0, 0, '0, 1);
    chk("t6_pvld", DW'(last_pvld), 0);
    chk("t6_count", DW'(fifo_count), 0);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, '0, 1);
      chk("t6_no_stale", DW'(last_pvld), 0);
    end
    cyc(0, 1, DW'(12345), 1);
    for (int i = 1; i < 4; i++) begin
      cyc(0, 0, '0, 1);
      chk("t6_lat_pvld0", DW'(last_pvld), 0);
    end
    cyc(0, 0, '0, 1);
    chk("t6_lat_pvld", DW'(last_pvld), 1);
    chk("t6_lat_pd", last_pd, DW'(12345));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
